bitonic_4_loader: RTL and testbench
===================================

BITONIC_4_LOADER -- requirements
Module: bitonic_4_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the element data width in bits.
REQ-002 Parameter LABEL_WIDTH, default 1, SHALL set the per-element label width in bits.
REQ-003 Parameter SIGNED, default 0, SHALL select two's-complement (1) or unsigned (0) comparison.
REQ-004 Parameter ASCENDING, default 1, SHALL set the direction of the downstream 4-input bitonic merger.
REQ-005 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 s_valid  in  1  input element present.
REQ-008 s_ready  out  1  loader can accept an element.
REQ-009 s_data  in  DATA_WIDTH  element value.
REQ-010 s_label  in  LABEL_WIDTH  element label.
REQ-011 s_last  in  1  marks the final element of a partial group, forcing a padded flush.
REQ-012 x_0..x_3  out  DATA_WIDTH each  bitonic 4-tuple for the merger.
REQ-013 x_label_0..x_label_3  out  LABEL_WIDTH each  labels that travel with x_0..x_3.
REQ-014 x_valid  out  1  one-cycle strobe marking a valid tuple.
REQ-015 group_cnt  out  16  count of tuples emitted, wrapping.

Function
REQ-016 An element SHALL be accepted on a rising edge with s_valid=1 and s_ready=1; s_ready SHALL be 1 whenever rst is deasserted.
REQ-017 A 2-bit slot index (0..3) SHALL place accepted elements into slots 0,1,2,3 in arrival order.
REQ-018 On acceptance into slot 1, the held slot-0 element and the new element SHALL be written to x_0/x_1 sorted in the ASCENDING direction (ascending: x_0<=x_1).
REQ-019 On acceptance into slot 3, the held slot-2 element and the new element SHALL be written to x_2/x_3 sorted opposite to ASCENDING (ascending: x_2>=x_3).
REQ-020 For equal values, the earlier-arrived element SHALL occupy the lower-numbered output; labels SHALL always move with their data.
REQ-021 Comparison SHALL be signed when SIGNED=1 and unsigned otherwise.
REQ-022 x_valid SHALL pulse high for exactly one cycle, in the cycle after the edge that accepts the slot-3 element; the slot index then returns to 0.
REQ-023 x_0..x_3 and their labels SHALL be registered and held stable from the x_valid pulse until the next x_valid pulse.
REQ-024 An element accepted with s_last=1 in slot k<3 SHALL complete the group, filling slots k+1..3 with PAD and label 0, with x_valid in the next cycle and the index reset to 0.
REQ-025 PAD SHALL be the value that sorts last: ascending gives the all-ones value (unsigned) or 0x7F.. (signed); descending gives zero (unsigned) or 0x80.. (signed).
REQ-026 Padded pairs SHALL be ordered by the same rules as REQ-018/019, so the tuple stays bitonic.
REQ-027 s_last on a slot-3 element SHALL behave as a normal group completion.
REQ-028 Back-to-back groups SHALL be accepted with no bubble, and a new group's element 0 may be accepted in the x_valid cycle.
REQ-029 group_cnt SHALL increment by 1 at each x_valid and wrap from 0xFFFF to 0x0000.

Reset
REQ-030 While rst=0, the block SHALL drive s_ready=0, x_valid=0, x_0..x_3=0, all labels=0, group_cnt=0 and slot index=0, asynchronously.
REQ-031 A partial group held when rst asserts SHALL be discarded, with no x_valid for it after release.
REQ-032 The first element after rst releases SHALL go to slot 0.

Verification
REQ-033 ASCENDING=1, SIGNED=0, stream 5,3,1,7 -> x_valid one cycle after 7; x=(3,5,7,1); group_cnt=1.
REQ-034 ASCENDING=1, stream 4,2,6 with s_last on 6 -> x=(2,4,0xFF,6); labels of pad slot=0; next element lands in slot 0.
REQ-035 ASCENDING=0, SIGNED=1, stream -1,3,-5,2 (0xFF,0x03,0xFB,0x02) -> x=(3,-1,-5,2).
REQ-036 Equal values 9(label 1),9(label 0),9,9 -> x_label_0=1, x_label_1=0; 8 continuous groups -> 8 single-cycle x_valid pulses, no gaps.
REQ-037 Accept 2 elements, pulse rst low mid-cycle -> outputs 0 immediately; then stream 1,2,3,4 -> x=(1,2,4,3), group_cnt=1.
REQ-038 Preload group_cnt to 0xFFFF via 65535 groups, emit one more -> group_cnt=0x0000.

Source files
------------

// File: rtl/bitonic_4_loader.sv
// Groups a stream of labelled elements into bitonic 4-tuples:
// the first pair is sorted one way and the second pair the other way.
module bitonic_4_loader #(
  parameter int DATA_WIDTH  = 8,
  parameter int LABEL_WIDTH = 1,
  parameter bit SIGNED      = 1'b0,
  parameter bit ASCENDING   = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [DATA_WIDTH-1:0]  s_data,
  input  logic [LABEL_WIDTH-1:0] s_label,
  input  logic                   s_last,
  output logic [DATA_WIDTH-1:0]  x_0,
  output logic [DATA_WIDTH-1:0]  x_1,
  output logic [DATA_WIDTH-1:0]  x_2,
  output logic [DATA_WIDTH-1:0]  x_3,
  output logic [LABEL_WIDTH-1:0] x_label_0,
  output logic [LABEL_WIDTH-1:0] x_label_1,
  output logic [LABEL_WIDTH-1:0] x_label_2,
  output logic [LABEL_WIDTH-1:0] x_label_3,
  output logic                   x_valid,
  output logic [15:0]            group_cnt
);

  localparam int DW = DATA_WIDTH;
  localparam int LW = LABEL_WIDTH;

  // Pad value always sorts to the tail of the first pair.
  localparam logic [DW-1:0] PAD =
    ASCENDING ? (SIGNED ? {1'b0, {(DW-1){1'b1}}} : {DW{1'b1}})
              : (SIGNED ? {1'b1, {(DW-1){1'b0}}} : {DW{1'b0}});

  function automatic logic lt(input logic [DW-1:0] a,
                              input logic [DW-1:0] b);
    if (SIGNED) return $signed(a) < $signed(b);
    else        return a < b;
  endfunction

  logic [1:0]    slot_q, slot_d;
  logic [DW-1:0] hd_q, hd_d;
  logic [LW-1:0] hl_q, hl_d;
  logic [DW-1:0] l0_q, l0_d, l1_q, l1_d;
  logic [LW-1:0] ll0_q, ll0_d, ll1_q, ll1_d;
  logic [DW-1:0] x0_q, x0_d, x1_q, x1_d;
  logic [DW-1:0] x2_q, x2_d, x3_q, x3_d;
  logic [LW-1:0] xl0_q, xl0_d, xl1_q, xl1_d;
  logic [LW-1:0] xl2_q, xl2_d, xl3_q, xl3_d;
  logic          xv_q, xv_d;
  logic [15:0]   cnt_q, cnt_d;

  logic          acc, emit, sw1, sw2;
  logic [DW-1:0] a1, b1, a2, b2, p0, p1, q0, q1;
  logic [LW-1:0] al1, bl1, al2, bl2, pl0, pl1, ql0, ql1;

  assign s_ready = rst;

  always_comb begin
    acc  = s_valid & s_ready;
    emit = acc & (s_last | (slot_q == 2'd3));

    a1  = (slot_q == 2'd0) ? s_data : hd_q;
    al1 = (slot_q == 2'd0) ? s_label : hl_q;
    b1  = (slot_q == 2'd0) ? PAD : s_data;
    bl1 = (slot_q == 2'd0) ? '0 : s_label;
    sw1 = ASCENDING ? lt(b1, a1) : lt(a1, b1);
    p0  = sw1 ? b1 : a1;
    p1  = sw1 ? a1 : b1;
    pl0 = sw1 ? bl1 : al1;
    pl1 = sw1 ? al1 : bl1;

    a2  = (slot_q == 2'd3) ? hd_q :
          (slot_q == 2'd2) ? s_data : PAD;
    al2 = (slot_q == 2'd3) ? hl_q :
          (slot_q == 2'd2) ? s_label : '0;
    b2  = (slot_q == 2'd3) ? s_data : PAD;
    bl2 = (slot_q == 2'd3) ? s_label : '0;
    sw2 = ASCENDING ? lt(a2, b2) : lt(b2, a2);
    q0  = sw2 ? b2 : a2;
    q1  = sw2 ? a2 : b2;
    ql0 = sw2 ? bl2 : al2;
    ql1 = sw2 ? al2 : bl2;
  end

  always_comb begin
    slot_d = slot_q;
    hd_d   = hd_q;
    hl_d   = hl_q;
    l0_d   = l0_q;
    l1_d   = l1_q;
    ll0_d  = ll0_q;
    ll1_d  = ll1_q;
    x0_d   = x0_q;
    x1_d   = x1_q;
    x2_d   = x2_q;
    x3_d   = x3_q;
    xl0_d  = xl0_q;
    xl1_d  = xl1_q;
    xl2_d  = xl2_q;
    xl3_d  = xl3_q;
    xv_d   = 1'b0;
    cnt_d  = cnt_q;
    if (acc) begin
      if (slot_q[0] == 1'b0) begin
        hd_d = s_data;
        hl_d = s_label;
      end
      if (slot_q == 2'd1) begin
        l0_d  = p0;
        l1_d  = p1;
        ll0_d = pl0;
        ll1_d = pl1;
      end
      if (emit) begin
        x0_d   = slot_q[1] ? l0_q : p0;
        x1_d   = slot_q[1] ? l1_q : p1;
        xl0_d  = slot_q[1] ? ll0_q : pl0;
        xl1_d  = slot_q[1] ? ll1_q : pl1;
        x2_d   = q0;
        x3_d   = q1;
        xl2_d  = ql0;
        xl3_d  = ql1;
        xv_d   = 1'b1;
        cnt_d  = cnt_q + 16'd1;
        slot_d = 2'd0;
      end else begin
        slot_d = slot_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_q <= '0;
      hd_q   <= '0;
      hl_q   <= '0;
      l0_q   <= '0;
      l1_q   <= '0;
      ll0_q  <= '0;
      ll1_q  <= '0;
      x0_q   <= '0;
      x1_q   <= '0;
      x2_q   <= '0;
      x3_q   <= '0;
      xl0_q  <= '0;
      xl1_q  <= '0;
      xl2_q  <= '0;
      xl3_q  <= '0;
      xv_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      slot_q <= slot_d;
      hd_q   <= hd_d;
      hl_q   <= hl_d;
      l0_q   <= l0_d;
      l1_q   <= l1_d;
      ll0_q  <= ll0_d;
      ll1_q  <= ll1_d;
      x0_q   <= x0_d;
      x1_q   <= x1_d;
      x2_q   <= x2_d;
      x3_q   <= x3_d;
      xl0_q  <= xl0_d;
      xl1_q  <= xl1_d;
      xl2_q  <= xl2_d;
      xl3_q  <= xl3_d;
      xv_q   <= xv_d;
      cnt_q  <= cnt_d;
    end
  end

  assign x_0       = x0_q;
  assign x_1       = x1_q;
  assign x_2       = x2_q;
  assign x_3       = x3_q;
  assign x_label_0 = xl0_q;
  assign x_label_1 = xl1_q;
  assign x_label_2 = xl2_q;
  assign x_label_3 = xl3_q;
  assign x_valid   = xv_q;
  assign group_cnt = cnt_q;

endmodule

// File: tb/tb_bitonic_4_loader.sv
// Directed bench for bitonic_4_loader: default unsigned/ascending
// instance plus a signed/descending instance.
module tb_bitonic_4_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid, s_valid2, s_last;
  logic [7:0] s_data;
  logic       s_label;

  logic       rdy1, xv1, rdy2, xv2;
  logic [7:0] a0, a1, a2, a3, b0, b1, b2, b3;
  logic       al0, al1, al2, al3, bl0, bl1, bl2, bl3;
  logic [15:0] cnt1, cnt2;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses, bad;

  always #5 clk = ~clk;

  bitonic_4_loader dut1 (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(rdy1),
    .s_data(s_data), .s_label(s_label), .s_last(s_last),
    .x_0(a0), .x_1(a1), .x_2(a2), .x_3(a3),
    .x_label_0(al0), .x_label_1(al1),
    .x_label_2(al2), .x_label_3(al3),
    .x_valid(xv1), .group_cnt(cnt1)
  );

  bitonic_4_loader #(.SIGNED(1'b1), .ASCENDING(1'b0)) dut2 (
    .clk(clk), .rst(rst),
    .s_valid(s_valid2), .s_ready(rdy2),
    .s_data(s_data), .s_label(s_label), .s_last(s_last),
    .x_0(b0), .x_1(b1), .x_2(b2), .x_3(b3),
    .x_label_0(bl0), .x_label_1(bl1),
    .x_label_2(bl2), .x_label_3(bl3),
    .x_valid(xv2), .group_cnt(cnt2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic l,
                      input logic last, input logic which);
    s_data  = d;
    s_label = l;
    s_last  = last;
    if (which) s_valid2 = 1'b1;
    else       s_valid  = 1'b1;
    @(posedge clk);
    #1;
    s_valid  = 1'b0;
    s_valid2 = 1'b0;
    s_last   = 1'b0;
  endtask

  initial begin
    rst = 1'b0; s_valid = 1'b0; s_valid2 = 1'b0;
    s_last = 1'b0; s_data = '0; s_label = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, rdy1}, 32'd0);
    chk("rst_xvalid", {31'd0, xv1}, 32'd0);
    chk("rst_x0", {24'd0, a0}, 32'd0);
    chk("rst_cnt", {16'd0, cnt1}, 32'd0);
    rst = 1'b1;
    #1;
    chk("ready_up", {31'd0, rdy1}, 32'd1);

    // 5,3,1,7 -> (3,5,7,1)
    send(8'd5, 1'b0, 1'b0, 1'b0);
    send(8'd3, 1'b1, 1'b0, 1'b0);
    send(8'd1, 1'b0, 1'b0, 1'b0);
    chk("g1_early", {31'd0, xv1}, 32'd0);
    chk("g1_hold0", {24'd0, a0}, 32'd0);
    send(8'd7, 1'b1, 1'b0, 1'b0);
    chk("g1_xv", {31'd0, xv1}, 32'd1);
    chk("g1_x", {a0, a1, a2, a3}, 32'h03050701);
    chk("g1_lab", {28'd0, al0, al1, al2, al3}, 32'b1010);
    chk("g1_cnt", {16'd0, cnt1}, 32'd1);
    @(posedge clk);
    #1;
    chk("g1_pulse", {31'd0, xv1}, 32'd0);
    chk("g1_stable", {a0, a1, a2, a3}, 32'h03050701);

    // 4,2,6(last) -> (2,4,FF,6)
    send(8'd4, 1'b1, 1'b0, 1'b0);
    send(8'd2, 1'b1, 1'b0, 1'b0);
    send(8'd6, 1'b1, 1'b1, 1'b0);
    chk("pad_xv", {31'd0, xv1}, 32'd1);
    chk("pad_x", {a0, a1, a2, a3}, 32'h0204FF06);
    chk("pad_lab", {28'd0, al0, al1, al2, al3}, 32'b1101);
    send(8'd8, 1'b1, 1'b1, 1'b0);
    chk("slot0_x", {a0, a1, a2, a3}, 32'h08FFFFFF);
    chk("slot0_lab", {28'd0, al0, al1, al2, al3}, 32'b1000);
    chk("slot0_cnt", {16'd0, cnt1}, 32'd3);

    // equal values keep arrival order
    send(8'd9, 1'b1, 1'b0, 1'b0);
    send(8'd9, 1'b0, 1'b0, 1'b0);
    send(8'd9, 1'b1, 1'b0, 1'b0);
    send(8'd9, 1'b0, 1'b0, 1'b0);
    chk("eq_x", {a0, a1, a2, a3}, 32'h09090909);
    chk("eq_lab", {28'd0, al0, al1, al2, al3}, 32'b1010);

    // 8 groups back to back
    pulses = 0;
    bad = 0;
    s_valid = 1'b1;
    s_label = 1'b0;
    for (int i = 0; i < 32; i++) begin
      s_data = 8'(i);
      @(posedge clk);
      #1;
      if (xv1) pulses++;
      if (xv1 !== ((i % 4) == 3)) bad++;
      if (i == 3) chk("bb_first", {a0, a1, a2, a3}, 32'h00010302);
    end
    s_valid = 1'b0;
    chk("bb_pulses", pulses, 32'd8);
    chk("bb_gaps", bad, 32'd0);
    chk("bb_last", {a0, a1, a2, a3}, 32'h1C1D1F1E);
    chk("bb_cnt", {16'd0, cnt1}, 32'd12);

    // signed, descending: -1,3,-5,2 -> (3,-1,-5,2)
    send(8'hFF, 1'b0, 1'b0, 1'b1);
    send(8'h03, 1'b1, 1'b0, 1'b1);
    send(8'hFB, 1'b0, 1'b0, 1'b1);
    send(8'h02, 1'b1, 1'b0, 1'b1);
    chk("sd_xv", {31'd0, xv2}, 32'd1);
    chk("sd_x", {b0, b1, b2, b3}, 32'h03FFFB02);
    chk("sd_lab", {28'd0, bl0, bl1, bl2, bl3}, 32'b1001);
    send(8'h05, 1'b1, 1'b1, 1'b1);
    chk("sd_pad", {b0, b1, b2, b3}, 32'h05808080);
    chk("sd_cnt", {16'd0, cnt2}, 32'd2);

    // reset mid-group discards the partial group
    send(8'd50, 1'b0, 1'b0, 1'b0);
    send(8'd60, 1'b0, 1'b0, 1'b0);
    #3;
    rst = 1'b0;
    #1;
    chk("ar_x", {a0, a1, a2, a3}, 32'd0);
    chk("ar_cnt", {16'd0, cnt1}, 32'd0);
    chk("ar_rdy", {30'd0, rdy1, xv1}, 32'd0);
    #1;
    rst = 1'b1;
    send(8'd1, 1'b0, 1'b0, 1'b0);
    send(8'd2, 1'b0, 1'b0, 1'b0);
    chk("ar_nopart", {31'd0, xv1}, 32'd0);
    send(8'd3, 1'b0, 1'b0, 1'b0);
    send(8'd4, 1'b0, 1'b0, 1'b0);
    chk("ar_xv", {31'd0, xv1}, 32'd1);
    chk("ar_g", {a0, a1, a2, a3}, 32'h01020403);
    chk("ar_cnt1", {16'd0, cnt1}, 32'd1);

    // counter wrap, one-element groups each cycle
    s_data = 8'd0;
    s_last = 1'b1;
    s_valid = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    chk("cnt_max", {16'd0, cnt1}, 32'h0000FFFF);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last = 1'b0;
    chk("cnt_wrap", {16'd0, cnt1}, 32'd0);
    chk("cnt_xv", {31'd0, xv1}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
